lcd_hd44780_driver: RTL



---
 rtl/lcd_hd44780_driver.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/lcd_hd44780_driver.sv
// lcd_hd44780_driver: turns LSU LCD control-word requests into HD44780 write bus timing.
// Define LCD_INIT_SEQ_EN to add a power-on INIT wait plus the 0x38/0x0C/0x01/0x06 command sequence.
module lcd_hd44780_driver #(
  parameter int unsigned T_SETUP_CYC = 2,
  parameter int unsigned T_EN_CYC    = 12,
  parameter int unsigned T_HOLD_CYC  = 1,
  parameter int unsigned T_EXEC_CYC  = 2000,
  parameter int unsigned T_LONG_CYC  = 82000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lcd_reg,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_overrun
);
  // state   | meaning
  // IDLE    | waiting for a request or a pending entry
  // SETUP   | RS/DATA stable, EN low
  // EN_HIGH | EN strobe high
  // HOLD    | EN low, RS/DATA still held
  // EXEC    | LCD internal execution wait
  // INIT    | power-on wait and init command launcher
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EN_HIGH, S_HOLD, S_EXEC, S_INIT} state_t;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             start_q;
  logic             pend_vld;
  logic             pend_rs;
  logic [7:0]       pend_data;
  logic             req;
  logic             is_long;
  logic             unused_bits;

`ifdef LCD_INIT_SEQ_EN
  localparam logic [19:0] INIT_WAIT = 20'd749999;
  logic [19:0] init_cnt;
  logic [2:0]  init_idx;
  logic [7:0]  init_cmd;

  always_comb begin
    init_cmd = 8'h38;
    case (init_idx[1:0])
      2'd0: init_cmd = 8'h38;
      2'd1: init_cmd = 8'h0C;
      2'd2: init_cmd = 8'h01;
      2'd3: init_cmd = 8'h06;
      default: init_cmd = 8'h38;
    endcase
  end
`endif

  assign req         = i_lcd_reg[10] & ~start_q;
  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign is_long     = ~o_lcd_rs && (o_lcd_data[7:2] == 6'd0) && (o_lcd_data[1:0] != 2'd0);
  assign o_lcd_rw    = 1'b0;
  assign o_busy      = (state != S_IDLE) | pend_vld;
  assign unused_bits = ^{i_lcd_reg[30:11], i_lcd_reg[9]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
`ifdef LCD_INIT_SEQ_EN
      state    <= S_INIT;
      init_cnt <= INIT_WAIT;
      init_idx <= 3'd0;
`else
      state    <= S_IDLE;
`endif
      cnt        <= '0;
      start_q    <= 1'b0;
      pend_vld   <= 1'b0;
      pend_rs    <= 1'b0;
      pend_data  <= 8'h00;
      o_lcd_data <= 8'h00;
      o_lcd_rs   <= 1'b0;
      o_lcd_en   <= 1'b0;
      o_lcd_on   <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      start_q  <= i_lcd_reg[10];
      o_lcd_on <= i_lcd_reg[31];
      if (cnt != '0) cnt <= cnt - CNT_ONE;

      if (req && state != S_IDLE) begin
        if (!pend_vld) begin
          pend_vld  <= 1'b1;
          pend_rs   <= i_lcd_reg[8];
          pend_data <= i_lcd_reg[7:0];
        end else begin
          o_overrun <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (pend_vld) begin
            // A request arriving in the launch cycle refills the slot just freed.
            o_lcd_rs   <= pend_rs;
            o_lcd_data <= pend_data;
            pend_vld   <= req;
            pend_rs    <= i_lcd_reg[8];
            pend_data  <= i_lcd_reg[7:0];
            state      <= S_SETUP;
            cnt        <= LD_SETUP;
          end else if (req) begin
            o_lcd_rs   <= i_lcd_reg[8];
            o_lcd_data <= i_lcd_reg[7:0];
            state      <= S_SETUP;
            cnt        <= LD_SETUP;
          end
        end
        S_SETUP: if (cnt == '0) begin
          state    <= S_EN_HIGH;
          cnt      <= LD_EN;
          o_lcd_en <= 1'b1;
        end
        S_EN_HIGH: if (cnt == '0) begin
          state    <= S_HOLD;
          cnt      <= LD_HOLD;
          o_lcd_en <= 1'b0;
        end
        S_HOLD: if (cnt == '0) begin
          state <= S_EXEC;
          cnt   <= is_long ? LD_LONG : LD_EXEC;
        end
        S_EXEC: if (cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
          state <= (init_idx != 3'd4) ? S_INIT : S_IDLE;
`else
          state <= S_IDLE;
`endif
        end
`ifdef LCD_INIT_SEQ_EN
        S_INIT: begin
          if (init_cnt != 20'd0) begin
            init_cnt <= init_cnt - 20'd1;
          end else begin
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= init_cmd;
            init_idx   <= init_idx + 3'd1;
            state      <= S_SETUP;
            cnt        <= LD_SETUP;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
